// File: rtl/conv_sequencer.sv
// Tile sequencer for the convolution accelerator: loads one tile, issues the READ
// pair, waits the programmed latency, issues WRITE, captures the result and drains it.
package conv_seq_pkg;
  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2} accel_op_e;
endpackage

module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_OF_SET   = 128,
  parameter int IN_NUM_OF_SET = 16,
  parameter int OUT_SETS      = 8,
  parameter int LAT_W         = 8,
  parameter int TILE_W        = 16,
  localparam int IN_W  = IN_NUM_OF_SET * DATA_OF_SET * DATA_WIDTH,
  localparam int OUT_W = OUT_SETS * DATA_OF_SET * DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic [LAT_W-1:0]  latency,
  input  logic              tile_valid,
  output logic              tile_ready,
  input  logic [IN_W-1:0]   tile_data,
  output logic [IN_W-1:0]   acc_din,
  output accel_op_e         acc_op,
  input  logic [OUT_W-1:0]  acc_dout,
  input  logic              acc_dvalid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_READ0, S_READ1, S_WAIT, S_WRITE, S_DRAIN, S_FIN
  } state_e;

  state_e            state, state_nx;
  logic [TILE_W-1:0] tiles_q, tile_cnt;
  logic [LAT_W-1:0]  lat_q, lat_cnt;
  logic              tile_hs, res_hs, last_tile;

  assign tile_hs   = tile_valid & tile_ready;
  assign res_hs    = res_valid & res_ready;
  // one extra bit so num_tiles = 2^TILE_W-1 terminates without wrapping
  assign last_tile = ({1'b0, tile_cnt} + (TILE_W+1)'(1)) == {1'b0, tiles_q};

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start && !abort) state_nx = (num_tiles == '0) ? S_FIN : S_FETCH;
      S_FETCH: if (tile_hs) state_nx = S_READ0;
      S_READ0: state_nx = S_READ1;
      S_READ1: state_nx = S_WAIT;
      S_WAIT:  if (lat_cnt == '0) state_nx = S_WRITE;
      S_WRITE: state_nx = S_DRAIN;
      S_DRAIN: if (res_hs) state_nx = last_tile ? S_FIN : S_FETCH;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc_op     <= OP_NONE;
      acc_din    <= '0;
      res_data   <= '0;
      tiles_q    <= '0;
      tile_cnt   <= '0;
      lat_q      <= '0;
      lat_cnt    <= '0;
      tile_ready <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      tile_ready <= (state_nx == S_FETCH);
      res_valid  <= (state_nx == S_DRAIN);
      busy       <= (state_nx != S_IDLE);
      done       <= (state_nx == S_FIN);
      unique case (state_nx)
        S_READ0, S_READ1: acc_op <= OP_READ;
        S_WRITE:          acc_op <= OP_WRITE;
        default:          acc_op <= OP_NONE;
      endcase
      if (state == S_IDLE && start && !abort) begin
        tiles_q  <= num_tiles;
        lat_q    <= latency;
        tile_cnt <= '0;
      end
      if (tile_hs) acc_din <= tile_data;
      if (state == S_READ1) lat_cnt <= lat_q;
      else if (state == S_WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
      if (state == S_WRITE && acc_dvalid && !abort) res_data <= acc_dout;
      if (res_hs) tile_cnt <= tile_cnt + TILE_W'(1);
    end
  end

  // the accelerator must answer WRITE in the same cycle
  a_dvalid_on_write: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_WRITE) |-> acc_dvalid);

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer with a behavioural accelerator and a result scoreboard.
module tb_conv_sequencer;
  import conv_seq_pkg::*;

  localparam int DW = 8, DOS = 2, INS = 2, OS = 1, LW = 8, TW = 4;
  localparam int IN_W = INS * DOS * DW, OUT_W = OS * DOS * DW;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic [LW-1:0] latency = '0;
  logic tile_valid = 1'b0, tile_ready;
  logic [IN_W-1:0] tile_data, acc_din;
  accel_op_e acc_op;
  logic [OUT_W-1:0] acc_dout, res_data;
  logic acc_dvalid, res_valid, busy, done;
  logic res_ready = 1'b1;

  conv_sequencer #(.DATA_WIDTH(DW), .DATA_OF_SET(DOS), .IN_NUM_OF_SET(INS),
                   .OUT_SETS(OS), .LAT_W(LW), .TILE_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_tiles(num_tiles),
    .latency(latency), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_data(tile_data), .acc_din(acc_din), .acc_op(acc_op), .acc_dout(acc_dout),
    .acc_dvalid(acc_dvalid), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, n_pairs = 0, n_wr = 0, n_res = 0, n_done = 0, n_busy = 0, n_rdy = 0, n_op = 0;
  int run_len = 0, last_res_cyc = 0, done_cyc = 0;
  logic [7:0] tile_seq = 8'd1;
  logic tile_take = 1'b0, trace_en = 1'b0;
  logic [IN_W-1:0] cap = '0;
  logic [OUT_W-1:0] w_dout = '0;
  accel_op_e prev_op = OP_NONE;
  logic [OUT_W-1:0] exp_q[$];
  accel_op_e trace[$];

  function automatic logic [OUT_W-1:0] xf(input logic [IN_W-1:0] t);
    return t[31:16] ^ {t[7:0], t[15:8]} ^ 16'hA5C3;
  endfunction

  assign tile_data  = {tile_seq ^ 8'h5C, tile_seq + 8'h11, ~tile_seq, tile_seq * 8'd7};
  assign acc_dout   = xf(cap);
  assign acc_dvalid = (acc_op == OP_WRITE);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tile_take) tile_seq <= tile_seq + 8'd1;
  end

  // accelerator model, op accounting and scoreboard, all sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_op = OP_NONE;
      run_len = 0;
      tile_take = 1'b0;
    end else begin
      if (acc_op == OP_READ) begin
        if (prev_op != OP_READ) begin cap = acc_din; n_pairs++; end
        run_len++;
      end else if (prev_op == OP_READ) begin
        chk("read_run_len", 64'(run_len), 64'd2);
        run_len = 0;
      end
      if (acc_op == OP_WRITE) begin n_wr++; w_dout = acc_dout; end
      tile_take = tile_valid && tile_ready;
      if (tile_take) exp_q.push_back(xf(tile_data));
      if (res_valid && res_ready) begin
        n_res++;
        last_res_cyc = cyc;
        chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("res_data", 64'(res_data), 64'(exp_q.pop_front()));
        chk("res_vs_write_dout", 64'(res_data), 64'(w_dout));
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (busy) n_busy++;
      if (tile_ready) n_rdy++;
      if (acc_op != OP_NONE) n_op++;
      if (trace_en && busy) trace.push_back(acc_op);
      prev_op = acc_op;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [TW-1:0] n, input logic [LW-1:0] l);
    step();
    start = 1'b1; num_tiles = n; latency = l;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk(tag, 64'(seen), 64'd1);
    step();
  endtask

  task automatic wait_op_read(input string tag);
    bit seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (acc_op == OP_READ) begin seen = 1; break; end
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  // waits for a result (res_ready held low), optionally stalls, then accepts it
  task automatic accept(input int hold, input string tag);
    bit seen = 0;
    logic [OUT_W-1:0] held;
    int p0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (res_valid) begin seen = 1; break; end
    end
    chk(tag, 64'(seen), 64'd1);
    held = res_data;
    p0 = n_pairs;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_data_held", 64'(res_data), 64'(held));
      chk("stall_valid_held", 64'(res_valid), 64'd1);
      chk("stall_op_none", 64'(acc_op), 64'(OP_NONE));
    end
    if (hold > 0) chk("stall_no_read", 64'(n_pairs - p0), 64'd0);
    step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    accel_op_e exp_tr[10] = '{OP_NONE, OP_READ, OP_READ, OP_NONE, OP_NONE,
                              OP_NONE, OP_NONE, OP_WRITE, OP_NONE, OP_NONE};
    int w0, d0, r0, p0, b0, o0, k0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_acc_op", 64'(acc_op), 64'(OP_NONE));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tile_ready", 64'(tile_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_acc_din", 64'(acc_din), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    rst_n = 1'b1;
    tile_valid = 1'b1;

    // single tile, latency 3: op trace and done timing
    trace.delete();
    trace_en = 1'b1;
    d0 = n_done;
    pulse_start(4'd1, 8'd3);
    wait_done(40, "t1_done_seen");
    step();
    trace_en = 1'b0;
    chk("t1_trace_len", 64'(trace.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      if (i < trace.size()) chk("t1_trace_op", 64'(trace[i]), 64'(exp_tr[i]));
    chk("t1_done_after_hs", 64'(done_cyc - last_res_cyc), 64'd1);
    chk("t1_done_count", 64'(n_done - d0), 64'd1);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // four tiles, second result stalled 5 cycles
    res_ready = 1'b0;
    w0 = n_wr; d0 = n_done; r0 = n_res; p0 = n_pairs;
    pulse_start(4'd4, 8'd2);
    accept(0, "t2_res1");
    accept(5, "t2_res2");
    accept(0, "t2_res3");
    accept(0, "t2_res4");
    wait_done(20, "t2_done_seen");
    chk("t2_results", 64'(n_res - r0), 64'd4);
    chk("t2_read_pairs", 64'(n_pairs - p0), 64'd4);
    chk("t2_writes", 64'(n_wr - w0), 64'd4);
    chk("t2_done_count", 64'(n_done - d0), 64'd1);
    chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);
    res_ready = 1'b1;

    // zero-tile job
    b0 = n_busy; d0 = n_done; o0 = n_op; k0 = n_rdy;
    pulse_start(4'd0, 8'd0);
    repeat (6) step();
    chk("t3_busy_cycles", 64'(n_busy - b0), 64'd1);
    chk("t3_done_count", 64'(n_done - d0), 64'd1);
    chk("t3_no_ops", 64'(n_op - o0), 64'd0);
    chk("t3_no_tile_ready", 64'(n_rdy - k0), 64'd0);

    // abort during WAIT, then an immediate fresh job
    w0 = n_wr; d0 = n_done; r0 = n_res;
    pulse_start(4'd1, 8'd10);
    wait_op_read("t4_read_seen");
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("t4_abort_busy", 64'(busy), 64'd0);
    chk("t4_abort_op", 64'(acc_op), 64'(OP_NONE));
    chk("t4_abort_tile_ready", 64'(tile_ready), 64'd0);
    chk("t4_abort_res_valid", 64'(res_valid), 64'd0);
    exp_q.delete();
    pulse_start(4'd1, 8'd1);
    wait_done(40, "t4_done_seen");
    chk("t4_writes", 64'(n_wr - w0), 64'd1);
    chk("t4_done_count", 64'(n_done - d0), 64'd1);
    chk("t4_results", 64'(n_res - r0), 64'd1);

    // start during DRAIN is ignored
    res_ready = 1'b0;
    d0 = n_done; r0 = n_res; p0 = n_pairs;
    pulse_start(4'd2, 8'd0);
    for (int i = 0; i < 30 && !res_valid; i++) @(negedge clk);
    pulse_start(4'd7, 8'd9);
    accept(0, "t5_res1");
    accept(0, "t5_res2");
    wait_done(20, "t5_done_seen");
    repeat (4) step();
    chk("t5_results", 64'(n_res - r0), 64'd2);
    chk("t5_read_pairs", 64'(n_pairs - p0), 64'd2);
    chk("t5_done_count", 64'(n_done - d0), 64'd1);
    chk("t5_idle", 64'(busy), 64'd0);
    res_ready = 1'b1;

    // start and abort together in IDLE
    k0 = n_rdy; b0 = n_busy;
    step();
    start = 1'b1; abort = 1'b1; num_tiles = 4'd1;
    step();
    start = 1'b0; abort = 1'b0;
    repeat (3) step();
    chk("t6_no_busy", 64'(n_busy - b0), 64'd0);
    chk("t6_no_tile_ready", 64'(n_rdy - k0), 64'd0);

    // maximum tile count completes without wrap
    d0 = n_done; r0 = n_res;
    pulse_start(4'd15, 8'd0);
    wait_done(200, "t7_done_seen");
    chk("t7_results", 64'(n_res - r0), 64'd15);
    chk("t7_done_count", 64'(n_done - d0), 64'd1);
    chk("t7_sb_empty", 64'(exp_q.size()), 64'd0);

    // async reset while in READ0
    pulse_start(4'd3, 8'd5);
    wait_op_read("t8_read_seen");
    rst_n = 1'b0;
    #1;
    chk("t8_rst_op", 64'(acc_op), 64'(OP_NONE));
    chk("t8_rst_busy", 64'(busy), 64'd0);
    chk("t8_rst_tile_ready", 64'(tile_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    d0 = n_done; p0 = n_pairs;
    repeat (6) step();
    @(negedge clk);
    chk("t8_post_busy", 64'(busy), 64'd0);
    chk("t8_post_reads", 64'(n_pairs - p0), 64'd0);
    chk("t8_post_done", 64'(n_done - d0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
